// File: rtl/if_stage_pkg.sv
// Shared constants and types for the MIPS instruction-fetch stage.
// Optional feature macro used by the top: IF_PERF_CNT_EN (performance counters).
package if_stage_pkg;

   // Bubble word: sll $0,$0,0
   localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;

   // Byte distance between sequential instructions
   localparam int unsigned PC_INC = 4;

   // Saturation ceiling for the performance counters
   localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

   // Fetch-stage control FSM
   typedef enum logic {
      S_BOOT = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   // Action the IF/ID register takes on the next edge
   typedef enum logic [1:0] {
      IFID_HOLD   = 2'd0,
      IFID_BUBBLE = 2'd1,
      IFID_LOAD   = 2'd2
   } ifid_op_t;

   // Counter increment that sticks at all-ones instead of wrapping
   function automatic logic [31:0] sat_inc(input logic [31:0] value);
      return (value == CNT_MAX) ? value : value + 32'd1;
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats hold, hold beats memory-wait bubble,
// otherwise the fetched instruction and its PC+4 are captured as valid.
module if_id_reg
   import if_stage_pkg::*;
#(
   parameter int unsigned       ADDR_W    = 32,
   parameter logic [31:0]       NOP_INSTR = DEFAULT_NOP_INSTR
)(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              enable,
   input  logic              flush,
   input  logic              write,
   input  logic              ready,
   input  logic [31:0]       fetch_instr,
   input  logic [ADDR_W-1:0] fetch_pc4,
   output logic [31:0]       instr,
   output logic [ADDR_W-1:0] pc4,
   output logic              valid
);

   ifid_op_t op;

   // Select the register action from the stage controls in priority order
   always_comb begin
      // NOTE: default assigned first so every path drives op and no latch is inferred.
      op = IFID_HOLD;
      if (enable) begin
         if (flush)       op = IFID_BUBBLE;
         else if (!write) op = IFID_HOLD;
         else if (!ready) op = IFID_BUBBLE;
         else             op = IFID_LOAD;
      end
   end

   // Register update; reset leaves a bubble in place
   always_ff @(posedge clk_i) begin
      // NOTE: non-blocking assignments so all flops sample pre-edge values together.
      if (rst_i) begin
         instr <= NOP_INSTR;
         pc4   <= '0;
         valid <= 1'b0;
      end else begin
         case (op)
            IFID_BUBBLE: begin
               instr <= NOP_INSTR;
               pc4   <= '0;
               valid <= 1'b0;
            end
            IFID_LOAD: begin
               instr <= fetch_instr;
               pc4   <= fetch_pc4;
               valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, boot/run FSM, instruction-memory
// request and the IF/ID register. Define IF_PERF_CNT_EN to build the
// stall/flush/fetch counters; otherwise the counter ports read zero.
module if_fetch_stage
   import if_stage_pkg::*;
#(
   parameter int unsigned       ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0,
   parameter logic [31:0]       NOP_INSTR = DEFAULT_NOP_INSTR
)(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              PC_Write,
   input  logic              IF_ID_Write,
   input  logic              IF_Flush,
   input  logic              PCSrc,
   input  logic [ADDR_W-1:0] branch_target_i,
   output logic              imem_req_o,
   output logic [ADDR_W-1:0] imem_addr_o,
   input  logic [31:0]       imem_data_i,
   input  logic              imem_ready_i,
   output logic [ADDR_W-1:0] pc_o,
   output logic [ADDR_W-1:0] IF_ID_pc4_o,
   output logic [31:0]       IF_ID_instr_o,
   output logic              IF_ID_valid_o,
   output logic              misalign_err_o,
   output logic [31:0]       stall_cnt_o,
   output logic [31:0]       flush_cnt_o,
   output logic [31:0]       fetch_cnt_o
);

   state_t            state, state_next;
   logic              run;
   logic [ADDR_W-1:0] pc, pc_next, pc_plus4;
   logic              misalign, misalign_next;

   assign pc_plus4    = pc + ADDR_W'(PC_INC);
   assign pc_o        = pc;
   assign imem_addr_o = pc;

   // FSM state register
   always_ff @(posedge clk_i) begin
      if (rst_i) state <= S_BOOT;
      else       state <= state_next;
   end

   // FSM next state and request output; boot lasts exactly one cycle
   always_comb begin
      state_next = S_RUN;
      run        = (state == S_RUN);
      imem_req_o = run && !PCSrc;
   end

   // Next PC: redirect beats stall beats memory wait beats sequential advance
   always_comb begin
      pc_next       = pc;
      misalign_next = misalign;
      if (run) begin
         if (PCSrc) begin
            pc_next = {branch_target_i[ADDR_W-1:2], 2'b00};
            if (branch_target_i[1:0] != 2'b00) misalign_next = 1'b1;
         end else if (PC_Write && imem_ready_i) begin
            pc_next = pc_plus4;
         end
      end
   end

   // PC and sticky misalignment flag
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pc       <= RESET_PC;
         misalign <= 1'b0;
      end else begin
         pc       <= pc_next;
         misalign <= misalign_next;
      end
   end

   assign misalign_err_o = misalign;

   // A redirect squashes whatever is being fetched, same as an explicit flush
   if_id_reg #(
      .ADDR_W    (ADDR_W),
      .NOP_INSTR (NOP_INSTR)
   ) u_if_id_reg (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .enable      (run),
      .flush       (IF_Flush | PCSrc),
      .write       (IF_ID_Write),
      .ready       (imem_ready_i),
      .fetch_instr (imem_data_i),
      .fetch_pc4   (pc_plus4),
      .instr       (IF_ID_instr_o),
      .pc4         (IF_ID_pc4_o),
      .valid       (IF_ID_valid_o)
   );

`ifdef IF_PERF_CNT_EN
   logic [31:0] stall_cnt, flush_cnt, fetch_cnt;
   logic        stall_ev, flush_ev, fetch_ev;

   assign flush_ev = run && (IF_Flush || PCSrc);
   assign stall_ev = run && !PCSrc && (!PC_Write || !imem_ready_i);
   assign fetch_ev = run && !IF_Flush && !PCSrc && IF_ID_Write && imem_ready_i;

   // Saturating event counters
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
         fetch_cnt <= '0;
      end else begin
         if (stall_ev) stall_cnt <= sat_inc(stall_cnt);
         if (flush_ev) flush_cnt <= sat_inc(flush_cnt);
         if (fetch_ev) fetch_cnt <= sat_inc(fetch_cnt);
      end
   end

   assign stall_cnt_o = stall_cnt;
   assign flush_cnt_o = flush_cnt;
   assign fetch_cnt_o = fetch_cnt;
`else
   assign stall_cnt_o = '0;
   assign flush_cnt_o = '0;
   assign fetch_cnt_o = '0;
`endif

endmodule
